// File: rtl/dcp_nocbuffer_enc_if.sv
// Handshake bundle between a DCP message builder, the NoC encoder
// and the outgoing router port.
interface dcp_nocbuffer_enc_if #(
   parameter int DATA_BUF_TOTAL_SIZE = 512,
   parameter int NOC_DATA_WIDTH      = 64
);
   logic                           msg_val;
   logic [DATA_BUF_TOTAL_SIZE-1:0] msg;
   logic                           msg_rdy;
   logic                           noc_out_val;
   logic [NOC_DATA_WIDTH-1:0]      noc_out_data;
   logic                           noc_out_rdy;
   logic                           busy;
   logic                           len_err;

   modport master (
      output msg_val, msg, noc_out_rdy,
      input  msg_rdy, noc_out_val, noc_out_data, busy, len_err
   );

   modport slave (
      input  msg_val, msg, noc_out_rdy,
      output msg_rdy, noc_out_val, noc_out_data, busy, len_err
   );
endinterface

// File: rtl/dcp_nocbuffer_enc.sv
// Serializes one packed DCP message (header + payload) onto a NoC
// channel, one flit per cycle, clamping oversize header lengths.
module dcp_nocbuffer_enc #(
   parameter int DATA_BUF_TOTAL_SIZE = 512,
   parameter int NOC_DATA_WIDTH      = 64,
   parameter int MSG_LEN_LSB         = 22,
   parameter int MSG_LEN_WIDTH       = 8
) (
   input logic               clk,
   input logic               rst,
   dcp_nocbuffer_enc_if.slave bus
);
   localparam int MAX_FLITS = DATA_BUF_TOTAL_SIZE / NOC_DATA_WIDTH;
   localparam int IDX_W = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(MAX_FLITS - 1);
   localparam logic [MSG_LEN_WIDTH-1:0] CAP = MSG_LEN_WIDTH'(MAX_FLITS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                    state_q, state_d;
   logic [NOC_DATA_WIDTH-1:0] buf_q [MAX_FLITS];
   logic [IDX_W-1:0]          idx_q;
   logic [IDX_W-1:0]          len_q;
   logic                      len_err_q;
   logic [MSG_LEN_WIDTH-1:0]  hdr_len;
   logic                      over;
   logic                      accept;
   logic                      fire;
   logic                      last;

   assign hdr_len = bus.msg[MSG_LEN_LSB +: MSG_LEN_WIDTH];
   assign over    = hdr_len > CAP;
   assign last    = idx_q == len_q;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      fire    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.msg_val) begin
               accept  = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (bus.noc_out_rdy) begin
               fire = 1'b1;
               if (last) state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= '0;
         len_q     <= '0;
         len_err_q <= 1'b0;
         for (int i = 0; i < MAX_FLITS; i++) buf_q[i] <= '0;
      end else begin
         len_err_q <= accept && over;
         if (accept) begin
            for (int i = 0; i < MAX_FLITS; i++)
               buf_q[i] <= bus.msg[i*NOC_DATA_WIDTH +: NOC_DATA_WIDTH];
            // keep the forwarded header consistent with what we send
            if (over) buf_q[0][MSG_LEN_LSB +: MSG_LEN_WIDTH] <= CAP;
            len_q <= over ? LAST : IDX_W'(hdr_len);
            idx_q <= '0;
         end else if (fire) begin
            idx_q <= last ? '0 : idx_q + 1'b1;
         end
      end
   end

   assign bus.msg_rdy      = state_q == IDLE;
   assign bus.noc_out_val  = state_q == SEND;
   assign bus.busy         = state_q == SEND;
   assign bus.len_err      = len_err_q;
   assign bus.noc_out_data = (state_q == SEND) ? buf_q[idx_q] : '0;
endmodule

// File: tb/tb_dcp_nocbuffer_enc.sv
// Randomized bench for dcp_nocbuffer_enc against a message-level
// reference model of the expected flit sequence.
module tb_dcp_nocbuffer_enc;
   localparam int DW = 512;
   localparam int NW = 64;
   localparam int MF = DW / NW;
   localparam int LSB = 22;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dcp_nocbuffer_enc_if #(.DATA_BUF_TOTAL_SIZE(DW), .NOC_DATA_WIDTH(NW)) bus ();

   dcp_nocbuffer_enc #(
      .DATA_BUF_TOTAL_SIZE(DW),
      .NOC_DATA_WIDTH(NW),
      .MSG_LEN_LSB(LSB),
      .MSG_LEN_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int len);
      logic [DW-1:0] m;
      for (int i = 0; i < MF; i++) m[i*NW +: NW] = {$urandom, $urandom};
      m[LSB +: 8] = len[7:0];
      return m;
   endfunction

   // Entered at the negedge after acceptance; leaves at the negedge
   // after the last handshake.
   task automatic recv(input logic [DW-1:0] m, input bit keep,
                       input logic [DW-1:0] nxt, input int pct);
      logic [DW-1:0] mm;
      int len, n, k, cyc;
      bit rdy;
      mm  = m;
      len = int'(m[LSB +: 8]);
      if (len > MF - 1) mm[LSB +: 8] = 8'(MF - 1);
      n   = (len > MF - 1) ? MF : len + 1;
      k   = 0;
      cyc = 0;
      while (k < n && cyc < 300) begin
         chk("val", 64'(bus.noc_out_val), 64'd1);
         chk("data", bus.noc_out_data, mm[k*NW +: NW]);
         chk("busy", 64'(bus.busy), 64'd1);
         chk("rdy_send", 64'(bus.msg_rdy), 64'd0);
         chk("len_err", 64'(bus.len_err), 64'((cyc == 0) && (len > MF - 1)));
         if (cyc == 0) begin
            bus.msg_val = keep;
            bus.msg     = nxt;
         end
         rdy = $urandom_range(99) < pct;
         bus.noc_out_rdy = rdy;
         @(posedge clk);
         if (rdy) k++;
         @(negedge clk);
         cyc++;
      end
      if (k < n) chk("timeout", 64'd0, 64'd1);
      bus.noc_out_rdy = 1'b0;
      chk("rdy_back", 64'(bus.msg_rdy), 64'd1);
      chk("val_idle", 64'(bus.noc_out_val), 64'd0);
      chk("busy_idle", 64'(bus.busy), 64'd0);
      chk("len_err_idle", 64'(bus.len_err), 64'd0);
   endtask

   task automatic send(input int len, input int pct);
      logic [DW-1:0] m;
      m = mk(len);
      chk("rdy_pre", 64'(bus.msg_rdy), 64'd1);
      bus.msg_val = 1'b1;
      bus.msg     = m;
      @(posedge clk);
      @(negedge clk);
      recv(m, 1'b0, ~m, pct);
   endtask

   initial begin
      logic [DW-1:0] m1, m2;
      bus.msg_val     = 1'b0;
      bus.msg         = '0;
      bus.noc_out_rdy = 1'b0;
      #2;
      chk("rst_rdy", 64'(bus.msg_rdy), 64'd1);
      chk("rst_val", 64'(bus.noc_out_val), 64'd0);
      chk("rst_data", bus.noc_out_data, 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_len_err", 64'(bus.len_err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      send(0, 100);
      send(3, 50);
      send(7, 100);
      send(20, 100);
      send(255, 60);

      // back-to-back with msg_val held high
      m1 = mk(1);
      m2 = mk(2);
      bus.msg_val = 1'b1;
      bus.msg     = m1;
      @(posedge clk);
      @(negedge clk);
      recv(m1, 1'b1, m2, 100);
      @(posedge clk);
      @(negedge clk);
      recv(m2, 1'b0, ~m2, 100);

      // async reset after the second of five flits
      m1 = mk(4);
      bus.msg_val = 1'b1;
      bus.msg     = m1;
      @(posedge clk);
      @(negedge clk);
      bus.msg_val = 1'b0;
      chk("ar_flit0", bus.noc_out_data, m1[0 +: NW]);
      bus.noc_out_rdy = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("ar_val", 64'(bus.noc_out_val), 64'd0);
      chk("ar_rdy", 64'(bus.msg_rdy), 64'd1);
      chk("ar_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      bus.noc_out_rdy = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      send(0, 100);

      for (int t = 0; t < 60; t++) begin
         int len;
         len = ($urandom_range(3) == 0) ? int'($urandom_range(8, 255))
                                        : int'($urandom_range(0, 7));
         send(len, int'($urandom_range(30, 100)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
